// File: rtl/prbs8_checker.sv
// Self-synchronising checker for the 8-bit PRBS byte stream: hunts, syncs, then flywheels.
// Optional build macro PRBS8_CHK_BITERR_EN: err_count accumulates mismatched bits instead of bytes.
module prbs8_checker #(
  parameter int LOCK_COUNT = 4,
  parameter int LOSE_COUNT = 3,
  parameter int ERR_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  input  logic             err_clr,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [3:0] LOCK_CNT = 4'(LOCK_COUNT);
  localparam logic [3:0] LOSE_CNT = 4'(LOSE_COUNT);

  state_t     state_reg;
  logic [7:0] prev_reg;
  logic [3:0] run_reg;
  logic [3:0] miss_reg;

  logic [7:0]       predicted;
  logic             mismatch;
  logic [3:0]       inc;
  logic [ERR_W:0]   sum;
  logic [ERR_W-1:0] count_next;

  // Eight single-bit LFSR steps: the byte the generator emits after prev.
  function automatic logic [7:0] step8(input logic [7:0] s);
    logic [7:0] x;
    x = s;
    for (int i = 0; i < 8; i++) begin
      x = {x[7] ^ x[1], x[7:1]};
    end
    return x;
  endfunction

  always_comb begin
    predicted = step8(prev_reg);
    mismatch  = (in_data != predicted);
`ifdef PRBS8_CHK_BITERR_EN
    inc = 4'($countones(in_data ^ predicted));
`else
    inc = 4'd1;
`endif
    sum        = {1'b0, err_count} + {{(ERR_W-3){1'b0}}, inc};
    count_next = sum[ERR_W] ? {ERR_W{1'b1}} : sum[ERR_W-1:0];
  end

  assign state_o = state_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= HUNT;
      prev_reg  <= 8'h00;
      run_reg   <= 4'd0;
      miss_reg  <= 4'd0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_count <= '0;
    end else begin
      err_pulse <= 1'b0;
      if (in_valid) begin
        case (state_reg)
          HUNT: begin
            // Zero is the LFSR's fixed point, never a usable seed.
            if (in_data != 8'h00) begin
              prev_reg  <= in_data;
              run_reg   <= 4'd0;
              state_reg <= SYNC;
            end
          end
          SYNC: begin
            if (!mismatch) begin
              prev_reg <= in_data;
              run_reg  <= run_reg + 4'd1;
              if (run_reg + 4'd1 == LOCK_CNT) begin
                state_reg <= LOCKED;
                locked    <= 1'b1;
                miss_reg  <= 4'd0;
              end
            end else if (in_data != 8'h00) begin
              prev_reg <= in_data;
              run_reg  <= 4'd0;
            end else begin
              state_reg <= HUNT;
            end
          end
          LOCKED: begin
            // Flywheel on the prediction; received data never reseeds here.
            prev_reg <= predicted;
            if (!mismatch) begin
              miss_reg <= 4'd0;
            end else begin
              err_pulse <= 1'b1;
              err_count <= count_next;
              miss_reg  <= miss_reg + 4'd1;
              if (miss_reg + 4'd1 == LOSE_CNT) begin
                state_reg <= HUNT;
                locked    <= 1'b0;
                run_reg   <= 4'd0;
                miss_reg  <= 4'd0;
              end
            end
          end
          default: state_reg <= HUNT;
        endcase
      end
      if (err_clr) begin
        err_count <= '0;
      end
    end
  end

endmodule
